// File: rtl/tnn_frame_seq.sv
// Frame sequencer for an external ternary-feature classifier: collects up to seven
// 2-bit feature beats, holds them for the core, samples its decision and keeps result statistics.
module tnn_frame_seq #(
   parameter int unsigned CORE_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_feat,
   input  logic        in_last,
   output logic [1:0]  core_a,
   output logic [1:0]  core_b,
   output logic [1:0]  core_c,
   output logic [1:0]  core_d,
   output logic [1:0]  core_e,
   output logic [1:0]  core_f,
   output logic [1:0]  core_g,
   input  logic        core_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_class,
   output logic        out_err,
   input  logic        cnt_clr,
   output logic [15:0] cnt_total,
   output logic [15:0] cnt_pos
);

   // state     | meaning
   // S_COLLECT | accepting feature beats into slots 0..6
   // S_EVAL    | slots frozen, waiting CORE_LAT cycles for the core to settle
   // S_HOLD    | result registered, waiting for the consumer
   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_EVAL    = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   localparam logic [3:0] LAT_LOAD = 4'(CORE_LAT - 1);

   state_t      state_q;
   logic [2:0]  idx_q;
   logic [1:0]  slot_q [7];
   logic [3:0]  lat_cnt_q;
   logic        err_q;
   logic [15:0] tot_q;
   logic [15:0] pos_q;
   logic        accept;
   logic        consume;

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_COLLECT;
         idx_q     <= 3'd0;
         for (int i = 0; i < 7; i++) slot_q[i] <= 2'd0;
         lat_cnt_q <= 4'd0;
         err_q     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_class <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         case (state_q)
            S_COLLECT: begin
               if (accept) begin
                  for (int i = 0; i < 7; i++) begin
                     if (idx_q == 3'(i)) slot_q[i] <= in_feat;
                  end
                  if (in_last || idx_q == 3'd6) begin
                     state_q   <= S_EVAL;
                     idx_q     <= 3'd0;
                     in_ready  <= 1'b0;
                     lat_cnt_q <= LAT_LOAD;
                     // only a last beat landing exactly in slot 6 is a well-formed frame
                     err_q     <= !(in_last && idx_q == 3'd6);
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            S_EVAL: begin
               if (lat_cnt_q == 4'd0) begin
                  out_class <= core_out;
                  out_err   <= err_q;
                  out_valid <= 1'b1;
                  state_q   <= S_HOLD;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 4'd1;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  state_q   <= S_COLLECT;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  err_q     <= 1'b0;
                  for (int i = 0; i < 7; i++) slot_q[i] <= 2'd0;
               end
            end
            default: state_q <= S_COLLECT;
         endcase
      end
   end

   // clear dominates any increment landing on the same edge
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         tot_q <= 16'd0;
         pos_q <= 16'd0;
      end else if (consume) begin
         if (tot_q != 16'hFFFF) tot_q <= tot_q + 16'd1;
         if (!out_err && out_class && pos_q != 16'hFFFF) pos_q <= pos_q + 16'd1;
      end
   end

   assign core_a    = slot_q[0];
   assign core_b    = slot_q[1];
   assign core_c    = slot_q[2];
   assign core_d    = slot_q[3];
   assign core_e    = slot_q[4];
   assign core_f    = slot_q[5];
   assign core_g    = slot_q[6];
   assign cnt_total = tot_q;
   assign cnt_pos   = pos_q;

endmodule

// File: tb/tb_tnn_frame_seq.sv
// Directed bench for tnn_frame_seq: cycle table for CORE_LAT=1 plus hand sequences,
// and a second instance with CORE_LAT=4 for latency and backpressure.
module tb_tnn_frame_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0, in_ready, in_last = 1'b0, core_out = 1'b0;
   logic [1:0]  in_feat = 2'd0;
   logic [1:0]  core_a, core_b, core_c, core_d, core_e, core_f, core_g;
   logic        out_valid, out_ready = 1'b0, out_class, out_err, cnt_clr = 1'b0;
   logic [15:0] cnt_total, cnt_pos;
   logic [13:0] slots;

   logic        in_valid_4 = 1'b0, in_ready_4, in_last_4 = 1'b0, core_out_4 = 1'b0;
   logic [1:0]  in_feat_4 = 2'd0;
   logic [1:0]  core_a_4, core_b_4, core_c_4, core_d_4, core_e_4, core_f_4, core_g_4;
   logic        out_valid_4, out_ready_4 = 1'b0, out_class_4, out_err_4;
   logic [15:0] cnt_total_4, cnt_pos_4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign slots = {core_a, core_b, core_c, core_d, core_e, core_f, core_g};

   tnn_frame_seq #(.CORE_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
      .in_last(in_last), .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
      .core_e(core_e), .core_f(core_f), .core_g(core_g), .core_out(core_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err),
      .cnt_clr(cnt_clr), .cnt_total(cnt_total), .cnt_pos(cnt_pos));

   tnn_frame_seq #(.CORE_LAT(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4), .in_feat(in_feat_4),
      .in_last(in_last_4), .core_a(core_a_4), .core_b(core_b_4), .core_c(core_c_4),
      .core_d(core_d_4), .core_e(core_e_4), .core_f(core_f_4), .core_g(core_g_4),
      .core_out(core_out_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
      .out_class(out_class_4), .out_err(out_err_4), .cnt_clr(1'b0),
      .cnt_total(cnt_total_4), .cnt_pos(cnt_pos_4));

   typedef struct {
      logic        v;
      logic [1:0]  f;
      logic        l;
      logic        co;
      logic        e_ird;
      logic        e_ov;
      logic        e_cls;
      logic        e_err;
      logic [13:0] e_slots;
      logic [15:0] e_tot;
      logic [15:0] e_pos;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic v, logic [1:0] f, logic l, logic co, logic ird, logic ov,
                               logic cls, logic err, logic [13:0] sl, logic [15:0] tot,
                               logic [15:0] pos);
      vec_t r;
      r.v = v; r.f = f; r.l = l; r.co = co; r.e_ird = ird; r.e_ov = ov; r.e_cls = cls;
      r.e_err = err; r.e_slots = sl; r.e_tot = tot; r.e_pos = pos;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // {v, feat, last, core_out} driven this cycle; expected outputs observed this cycle
      vecs.push_back(mk(1, 2'd1, 0, 0, 1, 0, 0, 0, 14'b00_00_00_00_00_00_00, 16'd0, 16'd0));
      vecs.push_back(mk(1, 2'd0, 0, 0, 1, 0, 0, 0, 14'b01_00_00_00_00_00_00, 16'd0, 16'd0));
      vecs.push_back(mk(1, 2'd2, 0, 0, 1, 0, 0, 0, 14'b01_00_00_00_00_00_00, 16'd0, 16'd0));
      vecs.push_back(mk(1, 2'd0, 0, 0, 1, 0, 0, 0, 14'b01_00_10_00_00_00_00, 16'd0, 16'd0));
      vecs.push_back(mk(1, 2'd3, 0, 0, 1, 0, 0, 0, 14'b01_00_10_00_00_00_00, 16'd0, 16'd0));
      vecs.push_back(mk(1, 2'd1, 0, 0, 1, 0, 0, 0, 14'b01_00_10_00_11_00_00, 16'd0, 16'd0));
      vecs.push_back(mk(1, 2'd2, 1, 0, 1, 0, 0, 0, 14'b01_00_10_00_11_01_00, 16'd0, 16'd0));
      vecs.push_back(mk(0, 2'd3, 1, 1, 0, 0, 0, 0, 14'b01_00_10_00_11_01_10, 16'd0, 16'd0));
      vecs.push_back(mk(0, 2'd0, 0, 0, 0, 1, 1, 0, 14'b01_00_10_00_11_01_10, 16'd0, 16'd0));
      // short frame 3,3
      vecs.push_back(mk(1, 2'd3, 0, 0, 1, 0, 0, 0, 14'b00_00_00_00_00_00_00, 16'd1, 16'd1));
      vecs.push_back(mk(1, 2'd3, 1, 0, 1, 0, 0, 0, 14'b11_00_00_00_00_00_00, 16'd1, 16'd1));
      vecs.push_back(mk(0, 2'd0, 0, 1, 0, 0, 0, 0, 14'b11_11_00_00_00_00_00, 16'd1, 16'd1));
      vecs.push_back(mk(0, 2'd0, 0, 0, 0, 1, 1, 1, 14'b11_11_00_00_00_00_00, 16'd1, 16'd1));
      // long frame 1,2,3,1,2,3,1 without last, core_out=0
      vecs.push_back(mk(1, 2'd1, 0, 0, 1, 0, 0, 0, 14'b00_00_00_00_00_00_00, 16'd2, 16'd1));
      vecs.push_back(mk(1, 2'd2, 0, 0, 1, 0, 0, 0, 14'b01_00_00_00_00_00_00, 16'd2, 16'd1));
      vecs.push_back(mk(1, 2'd3, 0, 0, 1, 0, 0, 0, 14'b01_10_00_00_00_00_00, 16'd2, 16'd1));
      vecs.push_back(mk(1, 2'd1, 0, 0, 1, 0, 0, 0, 14'b01_10_11_00_00_00_00, 16'd2, 16'd1));
      vecs.push_back(mk(1, 2'd2, 0, 0, 1, 0, 0, 0, 14'b01_10_11_01_00_00_00, 16'd2, 16'd1));
      vecs.push_back(mk(1, 2'd3, 0, 0, 1, 0, 0, 0, 14'b01_10_11_01_10_00_00, 16'd2, 16'd1));
      vecs.push_back(mk(1, 2'd1, 0, 0, 1, 0, 0, 0, 14'b01_10_11_01_10_11_00, 16'd2, 16'd1));
      vecs.push_back(mk(0, 2'd2, 1, 0, 0, 0, 0, 0, 14'b01_10_11_01_10_11_01, 16'd2, 16'd1));
      vecs.push_back(mk(0, 2'd0, 0, 1, 0, 1, 0, 1, 14'b01_10_11_01_10_11_01, 16'd2, 16'd1));
      // well-formed frame of 2s, last on beat 7, core_out=1
      vecs.push_back(mk(1, 2'd2, 0, 1, 1, 0, 0, 0, 14'b00_00_00_00_00_00_00, 16'd3, 16'd1));
      vecs.push_back(mk(1, 2'd2, 0, 1, 1, 0, 0, 0, 14'b10_00_00_00_00_00_00, 16'd3, 16'd1));
      vecs.push_back(mk(1, 2'd2, 0, 1, 1, 0, 0, 0, 14'b10_10_00_00_00_00_00, 16'd3, 16'd1));
      vecs.push_back(mk(1, 2'd2, 0, 1, 1, 0, 0, 0, 14'b10_10_10_00_00_00_00, 16'd3, 16'd1));
      vecs.push_back(mk(1, 2'd2, 0, 1, 1, 0, 0, 0, 14'b10_10_10_10_00_00_00, 16'd3, 16'd1));
      vecs.push_back(mk(1, 2'd2, 0, 1, 1, 0, 0, 0, 14'b10_10_10_10_10_00_00, 16'd3, 16'd1));
      vecs.push_back(mk(1, 2'd2, 1, 1, 1, 0, 0, 0, 14'b10_10_10_10_10_10_00, 16'd3, 16'd1));
      vecs.push_back(mk(0, 2'd0, 0, 1, 0, 0, 0, 0, 14'b10_10_10_10_10_10_10, 16'd3, 16'd1));
      vecs.push_back(mk(0, 2'd0, 0, 0, 0, 1, 1, 0, 14'b10_10_10_10_10_10_10, 16'd3, 16'd1));
      vecs.push_back(mk(0, 2'd0, 0, 0, 1, 0, 0, 0, 14'b00_00_00_00_00_00_00, 16'd4, 16'd2));

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_class", out_class, 0);
      chk("reset_out_err", out_err, 0);
      chk("reset_slots", slots, 0);
      chk("reset_cnt_total", cnt_total, 0);
      chk("reset_cnt_pos", cnt_pos, 0);

      out_ready = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         in_valid = vecs[i].v;
         in_feat  = vecs[i].f;
         in_last  = vecs[i].l;
         core_out = vecs[i].co;
         chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ird);
         chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
         chk($sformatf("vec%0d_slots", i), slots, vecs[i].e_slots);
         chk($sformatf("vec%0d_cnt_total", i), cnt_total, vecs[i].e_tot);
         chk($sformatf("vec%0d_cnt_pos", i), cnt_pos, vecs[i].e_pos);
         if (vecs[i].e_ov) begin
            chk($sformatf("vec%0d_out_class", i), out_class, vecs[i].e_cls);
            chk($sformatf("vec%0d_out_err", i), out_err, vecs[i].e_err);
         end
      end
      out_ready = 1'b0;

      // reset while in EVAL abandons the frame and clears counters
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_feat  = (i == 3) ? 2'd2 : 2'd0;
         in_last  = (i == 3);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("eval_core_d", core_d, 2);
      chk("eval_in_ready", in_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_eval_in_ready", in_ready, 1);
      chk("rst_eval_out_valid", out_valid, 0);
      chk("rst_eval_slots", slots, 0);
      chk("rst_eval_cnt_total", cnt_total, 0);
      chk("rst_eval_cnt_pos", cnt_pos, 0);

      // saturation of cnt_total
      @(negedge clk);
      in_valid = 1'b1; in_feat = 2'd1; in_last = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; core_out = 1'b1;
      @(negedge clk);
      chk("sat_out_valid", out_valid, 1);
      chk("sat_out_err", out_err, 1);
      force dut1.tot_q = 16'hFFFF;
      #1;
      release dut1.tot_q;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("sat_cnt_total", cnt_total, 16'hFFFF);
      chk("sat_cnt_pos", cnt_pos, 0);
      chk("sat_in_ready", in_ready, 1);

      // clear coincident with a consumption that would increment both counters
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_feat = 2'd2; in_last = (i == 6);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; core_out = 1'b1;
      @(negedge clk);
      chk("clr_out_valid", out_valid, 1);
      chk("clr_out_class", out_class, 1);
      chk("clr_out_err", out_err, 0);
      out_ready = 1'b1;
      cnt_clr = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      cnt_clr = 1'b0;
      chk("clr_cnt_total", cnt_total, 0);
      chk("clr_cnt_pos", cnt_pos, 0);
      chk("clr_in_ready", in_ready, 1);

      // CORE_LAT=4: latency, backpressure, and stability under held in_valid
      @(negedge clk);
      in_valid_4 = 1'b1; in_feat_4 = 2'd1; in_last_4 = 1'b1; out_ready_4 = 1'b0; core_out_4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_feat_4 = 2'd3;
         in_last_4 = 1'b0;
         chk($sformatf("lat4_eval%0d_out_valid", k), out_valid_4, 0);
         chk($sformatf("lat4_eval%0d_in_ready", k), in_ready_4, 0);
         if (k == 3) core_out_4 = 1'b1;
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("lat4_hold%0d_out_valid", k), out_valid_4, 1);
         chk($sformatf("lat4_hold%0d_in_ready", k), in_ready_4, 0);
         chk($sformatf("lat4_hold%0d_out_class", k), out_class_4, 1);
         chk($sformatf("lat4_hold%0d_core_a", k), core_a_4, 1);
         core_out_4 = k[0];
      end
      out_ready_4 = 1'b1;
      @(negedge clk);
      out_ready_4 = 1'b0;
      in_valid_4  = 1'b0;
      chk("lat4_after_in_ready", in_ready_4, 1);
      chk("lat4_after_out_valid", out_valid_4, 0);
      chk("lat4_cnt_total", cnt_total_4, 1);
      chk("lat4_cnt_pos", cnt_pos_4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tnn_frame_seq.md
TNN_FRAME_SEQ -- requirements
Module: tnn_frame_seq

Interface
REQ-001 Parameter: CORE_LAT, default 1, number of cycles the core inputs are held stable before core_out is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 in_valid  input  1  a feature beat is offered.
REQ-005 in_ready  output  1  the block accepts a beat this cycle.
REQ-006 in_feat  input  2  unsigned 2-bit feature value.
REQ-007 in_last  input  1  marks the final beat of a frame.
REQ-008 core_a, core_b, core_c, core_d, core_e, core_f, core_g  output  2 each  registered feature slots 0..6, driven to the external combinational classifier core.
REQ-009 core_out  input  1  classifier decision.
REQ-010 out_valid  output  1  a result is held.
REQ-011 out_ready  input  1  the downstream consumer takes the result.
REQ-012 out_class  output  1  the sampled core_out value.
REQ-013 out_err  output  1  framing error on this frame.
REQ-014 cnt_clr  input  1  synchronous clear of both statistics counters.
REQ-015 cnt_total  output  16  number of results consumed.
REQ-016 cnt_pos  output  16  number of error-free results consumed with out_class=1.

Function
REQ-017 The FSM SHALL have three states: COLLECT, EVAL and HOLD. in_ready SHALL be 1 only in COLLECT.
REQ-018 A beat is accepted when in_valid&in_ready=1. Each accepted beat SHALL write in_feat into slot idx (slot 0=core_a ... slot 6=core_g) and increment idx (3-bit, 0..6).
REQ-019 Frame completes when a beat is accepted with in_last=1, or when slot 6 is written, whichever comes first; the FSM then goes to EVAL and idx returns to 0.
REQ-020 Short frame (in_last=1 at idx<6): unwritten slots stay 0; the frame error flag is set.
REQ-021 Long frame (slot 6 written with in_last=0): the frame error flag is set; the next beat starts a new frame.
REQ-022 EVAL: core_a..core_g SHALL stay constant. A counter runs for CORE_LAT cycles. On the edge ending the last EVAL cycle, core_out is registered into out_class and the error flag into out_err, and the FSM goes to HOLD.
REQ-023 Latency: if the completing beat is accepted at edge E, out_valid SHALL be 1 from edge E+CORE_LAT onward.
REQ-024 HOLD: out_valid=1, and out_class and out_err SHALL be stable until out_valid&out_ready=1. On that edge the FSM goes to COLLECT, all seven slots clear to 0, and the error flag clears.
REQ-025 out_valid SHALL be 0 in COLLECT and EVAL. A result can be consumed in the same cycle out_valid first rises.
REQ-026 On each consumed result, cnt_total SHALL increment by 1.
REQ-027 On each consumed result with out_err=0 and out_class=1, cnt_pos SHALL increment by 1.
REQ-028 Both counters SHALL saturate at 0xFFFF with no wrap.
REQ-029 cnt_clr=1 SHALL clear both counters to 0; it wins over a simultaneous increment. It does not affect the FSM.
REQ-030 in_feat and in_last are ignored when no beat is accepted. core_out is ignored outside the sampling edge.

Reset
REQ-031 While rst=1 at an edge, the block SHALL go to: state COLLECT, idx=0, all slots 0, EVAL counter 0, out_valid=0, out_class=0, out_err=0, error flag 0, cnt_total=0, cnt_pos=0.
REQ-032 After reset, in_ready SHALL be 1 in the first cycle.
REQ-033 Reset asserted mid-frame, in EVAL or in HOLD SHALL abandon the partial frame or pending result with no counter update.

Verification
REQ-034 CORE_LAT=1; beats 1,0,2,0,3,1,2 with in_last on beat 7; bench core_out=1; out_ready=1 -> core_a..g = 1,0,2,0,3,1,2; out_valid one edge after beat 7; out_class=1, out_err=0; cnt_total=1, cnt_pos=1.
REQ-035 Short frame: beats 3,3 with in_last on beat 2 -> core_c..g=0; out_err=1; after consumption cnt_pos unchanged and cnt_total incremented.
REQ-036 Long frame: 7 beats with in_last=0, then 7 beats with in_last on beat 7 -> first result out_err=1, second result out_err=0.
REQ-037 CORE_LAT=4; out_ready held 0 for 10 cycles; in_valid held 1 -> out_valid rises at E+4; in_ready=0 and out_class stable throughout; in_ready=1 the cycle after consumption.
REQ-038 Preload cnt_total=0xFFFF; consume one result -> cnt_total stays 0xFFFF. cnt_clr coincident with a consumption -> both counters 0.
REQ-039 rst pulsed while in EVAL with core_d=2 -> next cycle in COLLECT, all slots 0, out_valid=0, counters 0.
